// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// The master side drives operands and commands; the unit drives status and HI/LO.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             mthi;
    logic             mtlo;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, in1, in2, mthi, mtlo, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, in1, in2, mthi, mtlo, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             sgn_op;
    logic             in_div;
    logic             div0;
    logic             fast_go;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign sgn_op = ~bus.op[0];
    assign in_div = bus.op[1];
    assign div0   = in_div && (bus.in2 == '0);

    assign mag1 = (sgn_op && bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;
    assign mag2 = (sgn_op && bus.in2[WIDTH-1]) ? -bus.in2 : bus.in2;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;

    assign fast_prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
    assign fast_go   = ~in_div;
`else
    assign fast_go   = 1'b0;
`endif

    // acc:sh is the running product, or remainder:quotient for divide
    assign mul_sum   = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc, sh[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_rem   = div_shift[WIDTH-1:0] - opnd;

    assign prod   = {acc, sh};
    assign prod_s = neg_q ? -prod : prod;

    always_comb begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
        if (is_div) begin
            res_hi = neg_r ? -acc : acc;
            res_lo = neg_q ? -sh : sh;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = fast_go ? FINISH : CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            acc     <= '0;
            sh      <= '0;
            opnd    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= '0;
                        is_div <= in_div;
                        acc    <= '0;
                        neg_q  <= sgn_op && !div0 &&
                                  (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
                        neg_r  <= sgn_op && in_div && !div0 &&
                                  bus.in1[WIDTH-1];
                        // x/0 runs unsigned on raw in1: quotient all ones, rem in1
                        if (in_div) begin
                            sh   <= div0 ? bus.in1 : mag1;
                            opnd <= mag2;
                        end else begin
                            sh   <= mag2;
                            opnd <= mag1;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        if (!in_div) begin
                            {acc, sh} <= fast_prod;
                        end
`endif
                    end else begin
                        if (bus.mthi) hi_q <= bus.in1;
                        if (bus.mtlo) lo_q <= bus.in1;
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        cnt <= cnt + 1'b1;
                        if (is_div) begin
                            acc <= div_ge ? div_rem : div_shift[WIDTH-1:0];
                            sh  <= {sh[WIDTH-2:0], div_ge};
                        end else begin
                            acc <= mul_sum[WIDTH:1];
                            sh  <= {mul_sum[0], sh[WIDTH-1:1]};
                        end
                    end
                end
                FINISH: begin
                    if (!bus.flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit beside the ALU in the execute stage.
- Takes the same two 32-bit register operands the ALU receives and computes MULT, MULTU, DIV or DIVU over multiple cycles.
- Holds the result in architectural HI/LO registers, which the writeback mux reads for MFHI/MFLO.
- The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU
- in1  input  WIDTH  rs operand (multiplicand/dividend)
- in2  input  WIDTH  rt operand (multiplier/divisor)
- mthi  input  1  write in1 into HI (IDLE only)
- mtlo  input  1  write in1 into LO (IDLE only)
- flush  input  1  synchronous cancel of an in-flight operation
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when HI/LO hold a new result
- hi  output  WIDTH  HI register (product high / remainder)
- lo  output  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset: rst_n=0 asynchronously forces state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and clears internal registers. Applies at any time, including mid-operation.
- FSM states: IDLE, CALC, FINISH.
- IDLE:
  - start=1 at edge T0 latches op and the operand magnitudes (absolute values for signed ops), records the result signs, clears the accumulator and counter, and goes to CALC. busy=1 from T0.
  - start has priority over mthi/mtlo in the same cycle.
- CALC:
  - One radix-2 step per edge: shift-add for multiply, restoring shift-subtract for divide.
  - Counter increments each step; after WIDTH steps (edge T32) go to FINISH.
- FINISH, edge T33:
  - Apply sign correction and write hi/lo.
  - done=1 for exactly the cycle after T33; busy=0 from T33.
  - Return to IDLE.
  - Total latency start→done is 33 edges.
- Multiply: {hi,lo} = full 64-bit product. MULT is two's-complement; MULTU is unsigned.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder taking the sign of the dividend.
  - Signed: -2^31 / -1 gives lo=0x80000000, hi=0.
  - Divide by zero (either signedness): lo=0xFFFFFFFF, hi=in1; still takes 33 edges.
- start while busy: ignored, no queueing.
- mthi/mtlo while busy: ignored.
- mthi and mtlo together in IDLE: both written.
- flush:
  - In CALC or FINISH, flush=1 returns the FSM to IDLE on the next edge, with busy=0, done=0 and hi/lo unchanged.
  - flush in IDLE has no effect.
  - flush and start together in IDLE: start is accepted.
- Operands are captured at start; in1/in2 changing during CALC does not affect the result.
- hi/lo change only at FINISH, on mthi/mtlo, or on reset.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU compute in a single cycle with a combinational 64-bit multiply. start at T0 writes hi/lo at T1, done=1 in the cycle after T1, and busy is high only during that one cycle. DIV/DIVU are unchanged at 33 edges.
- Undefined: all ops use the iterative path with 33-edge latency.
- Results must be bit-identical either way.

Test Plan:
- Reset mid-CALC: start MULT, assert rst_n=0 at cycle 10 → busy=0, done=0, hi=0, lo=0 immediately, without waiting for a clock edge.
- MULT in1=0xFFFFFFFF, in2=0x00000002 → done after 33 edges, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV in1=0xFFFFFFF9 (-7), in2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU in1=7, in2=0 → lo=0xFFFFFFFF, hi=0x00000007.
- Busy interactions:
  - Second start and mthi during busy → ignored; hi/lo equal the first op's result.
  - flush at cycle 5 → IDLE next edge, hi/lo keep their prior values, no done pulse.
